// File: rtl/npu_biu_pkg.sv
// Shared definitions for the NPU control/config bus interface unit.
// Holds the default bus widths, the CCR register window shared with the
// register block, AXI response codes and the access FSM state encoding.
package npu_biu_pkg;

  localparam int unsigned DEF_AXI_AW    = 32;
  localparam int unsigned DEF_CCR_DW    = 64;

  // CCR window: base .. base + 2**CCR_WIN_OS_AW - 1
  localparam int unsigned CCR_WIN_OS_AW = 12;
  localparam logic [31:0] CCR_WIN_BASE  = 32'h0001_0000;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_EXEC = 3'd1,
    WR_RESP = 3'd2,
    RD_EXEC = 3'd3,
    RD_RESP = 3'd4
  } biu_state_e;

endpackage

// File: rtl/npu_axil_skid.sv
// One-entry holding buffer for an AXI4-Lite request channel.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   valid_i/ready_o/data_i  upstream handshake; ready_o = !full (registered)
//   full_o, data_o          buffered payload presented to the consumer
//   pop_i                   consumer releases the entry
module npu_axil_skid #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             pop_i
);

  logic             full_q;
  logic             full_d;
  logic             ready_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             push;

  // Pop and push never coincide: ready is low while the entry is held.
  always_comb begin
    push   = valid_i && ready_q;
    full_d = full_q;
    data_d = data_q;
    if (pop_i) begin
      full_d = 1'b0;
    end
    if (push) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= !full_d;
      data_q  <= data_d;
    end
  end

  assign ready_o = ready_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

endmodule

// File: rtl/seu_npu_axil_biu.sv
// AXI4-Lite slave front end for the NPU CCR register file.
// Buffers AW/W/AR in one-entry holding buffers, arbitrates between a complete
// write and a read, issues a single-cycle reg_wen/reg_ren strobe and returns
// the B/R response. One access is in flight at a time.
// Ports:
//   clk_trans, rst            clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*           AXI4-Lite write address/data/response channels
//   s_ar*/s_r*                AXI4-Lite read address/data channels
//   reg_addr/wdata/sel        register access address (8-byte aligned), data, byte select
//   reg_wen/reg_ren           one-cycle write/read strobes
//   reg_rdata/reg_err         register read data and error, sampled in the strobe cycle
module seu_npu_axil_biu
  import npu_biu_pkg::*;
#(
  parameter int unsigned      AXI_AW     = DEF_AXI_AW,
  parameter int unsigned      CCR_AW     = DEF_AXI_AW,
  parameter int unsigned      CCR_DW     = DEF_CCR_DW,
  parameter int unsigned      CCR_OS_AW  = CCR_WIN_OS_AW,
  parameter logic [AXI_AW-1:0] CCR_S_ADDR = AXI_AW'(CCR_WIN_BASE)
) (
  input  logic                clk_trans,
  input  logic                rst,
  input  logic [AXI_AW-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [CCR_DW-1:0]   s_wdata,
  input  logic [CCR_DW/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [AXI_AW-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [CCR_DW-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [CCR_AW-1:0]   reg_addr,
  output logic [CCR_DW-1:0]   reg_wdata,
  output logic [CCR_DW/8-1:0] reg_sel,
  output logic                reg_wen,
  output logic                reg_ren,
  input  logic [CCR_DW-1:0]   reg_rdata,
  input  logic                reg_err
);

  localparam int unsigned SW = CCR_DW / 8;
  // Word address: byte-offset bits [2:0] are dropped at the buffer input.
  localparam int unsigned WA = AXI_AW - 3;

  typedef struct packed {
    logic [SW-1:0]     strb;
    logic [CCR_DW-1:0] data;
  } wbeat_t;

  logic          aw_full, w_full, ar_full;
  logic          aw_pop, w_pop, ar_pop;
  logic [WA-1:0] aw_wa, ar_wa;
  wbeat_t        w_in, w_beat;

  biu_state_e        state_q, state_d;
  logic              prio_q, prio_d;    // 0: write wins a tie, 1: read wins
  logic              win_q, win_d;      // current access hits the CCR window
  logic [CCR_AW-1:0] reg_addr_q, reg_addr_d;
  logic [CCR_DW-1:0] reg_wdata_q, reg_wdata_d;
  logic [SW-1:0]     reg_sel_q, reg_sel_d;
  logic              reg_wen_q, reg_wen_d;
  logic              reg_ren_q, reg_ren_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [CCR_DW-1:0] rdata_q, rdata_d;

  logic wr_pend, rd_pend, grant_wr, grant_rd;

  function automatic logic in_window(input logic [WA-1:0] wa);
    return wa[WA-1:CCR_OS_AW-3] == CCR_S_ADDR[AXI_AW-1:CCR_OS_AW];
  endfunction

  assign w_in = '{strb: s_wstrb, data: s_wdata};

  npu_axil_skid #(.WIDTH(WA)) u_aw_buf (
    .clk_i   (clk_trans),
    .rst_i   (rst),
    .valid_i (s_awvalid),
    .ready_o (s_awready),
    .data_i  (s_awaddr[AXI_AW-1:3]),
    .full_o  (aw_full),
    .data_o  (aw_wa),
    .pop_i   (aw_pop)
  );

  npu_axil_skid #(.WIDTH($bits(wbeat_t))) u_w_buf (
    .clk_i   (clk_trans),
    .rst_i   (rst),
    .valid_i (s_wvalid),
    .ready_o (s_wready),
    .data_i  (w_in),
    .full_o  (w_full),
    .data_o  (w_beat),
    .pop_i   (w_pop)
  );

  npu_axil_skid #(.WIDTH(WA)) u_ar_buf (
    .clk_i   (clk_trans),
    .rst_i   (rst),
    .valid_i (s_arvalid),
    .ready_o (s_arready),
    .data_i  (s_araddr[AXI_AW-1:3]),
    .full_o  (ar_full),
    .data_o  (ar_wa),
    .pop_i   (ar_pop)
  );

  // Round-robin tie break: priority only moves when both sides were waiting.
  always_comb begin
    wr_pend  = aw_full && w_full;
    rd_pend  = ar_full;
    grant_wr = wr_pend && (!rd_pend || !prio_q);
    grant_rd = rd_pend && !grant_wr;
  end

  // Access FSM: strobes are set up one cycle ahead so they leave a register.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    win_d       = win_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_sel_d   = reg_sel_q;
    reg_wen_d   = 1'b0;
    reg_ren_d   = 1'b0;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    aw_pop      = 1'b0;
    w_pop       = 1'b0;
    ar_pop      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d     = WR_EXEC;
          win_d       = in_window(aw_wa);
          reg_addr_d  = CCR_AW'({aw_wa, 3'b000});
          reg_wdata_d = w_beat.data;
          reg_sel_d   = w_beat.strb;
          reg_wen_d   = in_window(aw_wa) && (w_beat.strb != '0);
          if (rd_pend) begin
            prio_d = 1'b1;
          end
        end else if (grant_rd) begin
          state_d    = RD_EXEC;
          win_d      = in_window(ar_wa);
          reg_addr_d = CCR_AW'({ar_wa, 3'b000});
          reg_ren_d  = in_window(ar_wa);
          if (wr_pend) begin
            prio_d = 1'b0;
          end
        end
      end
      WR_EXEC: begin
        // reg_err only counts when a strobe was actually issued
        bresp_d  = (!win_q || (reg_wen_q && reg_err)) ? RESP_SLVERR : RESP_OKAY;
        bvalid_d = 1'b1;
        state_d  = WR_RESP;
      end
      WR_RESP: begin
        if (s_bready) begin
          bvalid_d = 1'b0;
          aw_pop   = 1'b1;
          w_pop    = 1'b1;
          state_d  = IDLE;
        end
      end
      RD_EXEC: begin
        rdata_d  = win_q ? reg_rdata : '0;
        rresp_d  = (!win_q || (reg_ren_q && reg_err)) ? RESP_SLVERR : RESP_OKAY;
        rvalid_d = 1'b1;
        state_d  = RD_RESP;
      end
      RD_RESP: begin
        if (s_rready) begin
          rvalid_d = 1'b0;
          ar_pop   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_trans) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      win_q       <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_sel_q   <= '0;
      reg_wen_q   <= 1'b0;
      reg_ren_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      win_q       <= win_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_sel_q   <= reg_sel_d;
      reg_wen_q   <= reg_wen_d;
      reg_ren_q   <= reg_ren_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
    end
  end

  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_sel   = reg_sel_q;
  assign reg_wen   = reg_wen_q;
  assign reg_ren   = reg_ren_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;

endmodule

// File: tb/tb_seu_npu_axil_biu.sv
// Self-checking bench for seu_npu_axil_biu: directed scenarios followed by
// randomized writes, reads and contested write/read pairs, checked against
// a transaction-level model of the CCR window, responses and arbitration.
module tb_seu_npu_axil_biu;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk_trans = 1'b0;
  logic        rst;
  logic [31:0] s_awaddr;
  logic        s_awvalid, s_awready;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_wvalid, s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid, s_arready;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid, s_rready;
  logic [31:0] reg_addr;
  logic [63:0] reg_wdata;
  logic [7:0]  reg_sel;
  logic        reg_wen, reg_ren;
  logic [63:0] reg_rdata;
  logic        reg_err;

  logic err_force;
  bit   exp_wr_first;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk_trans = ~clk_trans;

  // Register block model: fixed pattern per word, word base+8 reads 3.
  function automatic logic [63:0] reg_model(input logic [31:0] a);
    if (a == BASE + 32'h8) return 64'h3;
    return {~a, a ^ 32'h5A5A_5A5A};
  endfunction

  function automatic bit hit(input logic [31:0] a);
    return a[31:12] == BASE[31:12];
  endfunction

  assign reg_rdata = reg_model(reg_addr);
  assign reg_err   = err_force;

  seu_npu_axil_biu dut (
    .clk_trans (clk_trans), .rst       (rst),
    .s_awaddr  (s_awaddr),  .s_awvalid (s_awvalid), .s_awready (s_awready),
    .s_wdata   (s_wdata),   .s_wstrb   (s_wstrb),   .s_wvalid  (s_wvalid),  .s_wready (s_wready),
    .s_bresp   (s_bresp),   .s_bvalid  (s_bvalid),  .s_bready  (s_bready),
    .s_araddr  (s_araddr),  .s_arvalid (s_arvalid), .s_arready (s_arready),
    .s_rdata   (s_rdata),   .s_rresp   (s_rresp),   .s_rvalid  (s_rvalid),  .s_rready (s_rready),
    .reg_addr  (reg_addr),  .reg_wdata (reg_wdata), .reg_sel   (reg_sel),
    .reg_wen   (reg_wen),   .reg_ren   (reg_ren),
    .reg_rdata (reg_rdata), .reg_err   (reg_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_trans);
    #1;
  endtask

  task automatic idle_inputs();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    s_bready  = 1'b0; s_rready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ready"},  {s_awready, s_wready, s_arready}, 0);
    check_eq({tag, "_valid"},  {s_bvalid, s_rvalid}, 0);
    check_eq({tag, "_strobe"}, {reg_wen, reg_ren}, 0);
    check_eq({tag, "_addr"},   reg_addr, 0);
    check_eq({tag, "_wdata"},  reg_wdata, 0);
    check_eq({tag, "_sel"},    reg_sel, 0);
    check_eq({tag, "_resp"},   {s_bresp, s_rresp}, 0);
    check_eq({tag, "_rdata"},  s_rdata, 0);
  endtask

  // Write transaction with independent AW/W start delays and a B-ready delay
  // counted from the first cycle bvalid is seen.
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, input int aw_dly, input int w_dly,
                          input int b_dly, input logic err);
    int cyc = 0, hs_cyc = -1, wen_cyc = -1, b_first = -1, n_wen = 0, n_ren = 0;
    bit aw_done = 0, w_done = 0, b_done = 0, aw_hs, w_hs, exp_wen;
    logic [31:0] got_addr = '0;
    logic [63:0] got_data = '0;
    logic [7:0]  got_sel = '0;
    logic [1:0]  exp_resp;
    exp_wen  = hit(addr) && (strb != 8'h00);
    exp_resp = (!hit(addr) || (exp_wen && err)) ? 2'b10 : 2'b00;
    err_force = err;
    tick();
    while (!b_done && cyc < 100) begin
      if (reg_wen) begin
        n_wen++; wen_cyc = cyc; got_addr = reg_addr; got_data = reg_wdata; got_sel = reg_sel;
      end
      if (reg_ren) n_ren++;
      if (s_bvalid && b_first < 0) b_first = cyc;
      if (aw_done) check_eq({tag, "_awready_blocked"}, s_awready, 0);
      if (w_done)  check_eq({tag, "_wready_blocked"}, s_wready, 0);
      if (b_first >= 0) begin
        check_eq({tag, "_bvalid_held"}, s_bvalid, 1);
        check_eq({tag, "_bresp"}, s_bresp, exp_resp);
      end
      s_awaddr  = addr;
      s_awvalid = !aw_done && cyc >= aw_dly;
      s_wdata   = data;
      s_wstrb   = strb;
      s_wvalid  = !w_done && cyc >= w_dly;
      s_bready  = b_first >= 0 && (cyc - b_first) >= b_dly;
      aw_hs  = s_awvalid && s_awready;
      w_hs   = s_wvalid && s_wready;
      if ((aw_hs && (w_done || w_hs)) || (w_hs && aw_done)) hs_cyc = cyc;
      b_done = s_bvalid && s_bready;
      tick();
      cyc++;
      aw_done |= aw_hs;
      w_done  |= w_hs;
    end
    idle_inputs();
    check_eq({tag, "_completed"}, b_done, 1);
    check_eq({tag, "_wen_count"}, n_wen, exp_wen);
    check_eq({tag, "_no_ren"}, n_ren, 0);
    check_eq({tag, "_b_latency"}, b_first - hs_cyc, 3);
    if (exp_wen) begin
      check_eq({tag, "_wen_latency"}, wen_cyc - hs_cyc, 2);
      check_eq({tag, "_reg_addr"}, got_addr, {addr[31:3], 3'b000});
      check_eq({tag, "_reg_wdata"}, got_data, data);
      check_eq({tag, "_reg_sel"}, got_sel, strb);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input int r_dly,
                         input logic err);
    int cyc = 0, hs_cyc = -1, ren_cyc = -1, r_first = -1, n_wen = 0, n_ren = 0;
    bit ar_done = 0, r_done = 0, ar_hs, exp_ren;
    logic [31:0] al, got_addr = '0;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
    al       = {addr[31:3], 3'b000};
    exp_ren  = hit(addr);
    exp_data = exp_ren ? reg_model(al) : 64'h0;
    exp_resp = (!exp_ren || err) ? 2'b10 : 2'b00;
    err_force = err;
    tick();
    while (!r_done && cyc < 100) begin
      if (reg_ren) begin n_ren++; ren_cyc = cyc; got_addr = reg_addr; end
      if (reg_wen) n_wen++;
      if (s_rvalid && r_first < 0) r_first = cyc;
      if (ar_done) check_eq({tag, "_arready_blocked"}, s_arready, 0);
      if (r_first >= 0) begin
        check_eq({tag, "_rvalid_held"}, s_rvalid, 1);
        check_eq({tag, "_rresp"}, s_rresp, exp_resp);
        check_eq({tag, "_rdata"}, s_rdata, exp_data);
      end
      s_araddr  = addr;
      s_arvalid = !ar_done;
      s_rready  = r_first >= 0 && (cyc - r_first) >= r_dly;
      ar_hs  = s_arvalid && s_arready;
      if (ar_hs) hs_cyc = cyc;
      r_done = s_rvalid && s_rready;
      tick();
      cyc++;
      ar_done |= ar_hs;
    end
    idle_inputs();
    check_eq({tag, "_completed"}, r_done, 1);
    check_eq({tag, "_ren_count"}, n_ren, exp_ren);
    check_eq({tag, "_no_wen"}, n_wen, 0);
    check_eq({tag, "_r_latency"}, r_first - hs_cyc, 3);
    if (exp_ren) begin
      check_eq({tag, "_ren_latency"}, ren_cyc - hs_cyc, 2);
      check_eq({tag, "_reg_addr"}, got_addr, al);
    end
  endtask

  // Write and read presented in the same cycle; the model alternates the winner.
  task automatic do_both(input string tag, input logic [31:0] waddr, input logic [63:0] wdata,
                         input logic [31:0] raddr);
    int cyc = 0, b_first = -1, r_first = -1, n_wen = 0, n_ren = 0;
    bit aw_done = 0, w_done = 0, ar_done = 0, b_done = 0, r_done = 0;
    bit aw_hs, w_hs, ar_hs, b_hs, r_hs;
    err_force = 1'b0;
    tick();
    while (!(b_done && r_done) && cyc < 100) begin
      if (reg_wen) n_wen++;
      if (reg_ren) n_ren++;
      if (reg_wen || reg_ren) check_eq({tag, "_strobe_exclusive"}, reg_wen && reg_ren, 0);
      if (s_bvalid && b_first < 0) begin
        b_first = cyc;
        check_eq({tag, "_bresp"}, s_bresp, hit(waddr) ? 2'b00 : 2'b10);
      end
      if (s_rvalid && r_first < 0) begin
        r_first = cyc;
        check_eq({tag, "_rresp"}, s_rresp, hit(raddr) ? 2'b00 : 2'b10);
        check_eq({tag, "_rdata"}, s_rdata,
                 hit(raddr) ? reg_model({raddr[31:3], 3'b000}) : 64'h0);
      end
      s_awaddr = waddr; s_wdata = wdata; s_wstrb = 8'hFF; s_araddr = raddr;
      s_awvalid = !aw_done; s_wvalid = !w_done; s_arvalid = !ar_done;
      s_bready = 1'b1; s_rready = 1'b1;
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      ar_hs = s_arvalid && s_arready;
      b_hs  = s_bvalid && s_bready;
      r_hs  = s_rvalid && s_rready;
      tick();
      cyc++;
      aw_done |= aw_hs; w_done |= w_hs; ar_done |= ar_hs;
      b_done  |= b_hs;  r_done |= r_hs;
    end
    idle_inputs();
    check_eq({tag, "_completed"}, b_done && r_done, 1);
    check_eq({tag, "_wen_count"}, n_wen, hit(waddr));
    check_eq({tag, "_ren_count"}, n_ren, hit(raddr));
    check_eq({tag, "_write_first"}, b_first < r_first, exp_wr_first);
    exp_wr_first = !exp_wr_first;
  endtask

  // Start an access, apply reset once it reaches the requested phase, and
  // confirm that no response for it ever appears.
  task automatic reset_mid(input string tag, input bit is_write);
    int cyc = 0;
    bit reached = 0, a_done = 0, w_done = 0, a_hs, w_hs;
    err_force = 1'b0;
    tick();
    while (!reached && cyc < 100) begin
      reached = is_write ? reg_wen : s_rvalid;
      if (!reached) begin
        s_awaddr = BASE + 32'h20; s_wdata = 64'h1111_2222_3333_4444; s_wstrb = 8'hFF;
        s_araddr = BASE + 32'h28;
        s_awvalid = is_write && !a_done;
        s_wvalid  = is_write && !w_done;
        s_arvalid = !is_write && !a_done;
        a_hs = (s_awvalid && s_awready) || (s_arvalid && s_arready);
        w_hs = s_wvalid && s_wready;
        tick();
        cyc++;
        a_done |= a_hs;
        w_done |= w_hs;
      end
    end
    check_eq({tag, "_reached"}, reached, 1);
    idle_inputs();
    rst = 1'b1;
    tick();
    check_reset_vals(tag);
    rst = 1'b0;
    exp_wr_first = 1'b1;
    s_bready = 1'b1; s_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq({tag, "_no_response"}, {s_bvalid, s_rvalid}, 0);
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [7:0]  st;
    int          kind;
    rst = 1'b1; err_force = 1'b0; exp_wr_first = 1'b1;
    s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
    idle_inputs();
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    do_write("t1_write", BASE + 32'h410, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 0, 0, 1'b0);
    do_write("t2_w_first", BASE + 32'h18, 64'h0BAD_F00D_CAFE_0001, 8'h0F, 2, 0, 5, 1'b0);
    do_read("t3_read_hit", BASE + 32'h8, 0, 1'b0);
    do_read("t3_read_miss", 32'h2000_0000, 0, 1'b0);
    do_write("t3_write_miss", 32'h2000_0010, 64'h5, 8'hFF, 0, 0, 0, 1'b0);
    do_write("t3_unaligned", BASE + 32'h7F5, 64'h77, 8'h80, 1, 1, 2, 1'b0);

    rst = 1'b1; tick(); rst = 1'b0; exp_wr_first = 1'b1; tick();
    do_both("t4_pair1", BASE + 32'h100, 64'hA5A5, BASE + 32'h108);
    do_both("t4_pair2", BASE + 32'h110, 64'h5A5A, BASE + 32'h118);

    do_write("t5_strb0", BASE + 32'h30, 64'hFFFF, 8'h00, 0, 0, 0, 1'b0);
    do_write("t5_regerr", BASE + 32'h38, 64'hEEEE, 8'hFF, 0, 0, 0, 1'b1);
    do_read("t5_rd_regerr", BASE + 32'h40, 1, 1'b1);

    reset_mid("t6_rst_wr_exec", 1'b1);
    do_write("t6_after_wr", BASE + 32'h48, 64'h1234_5678_9ABC_DEF0, 8'hFF, 0, 0, 0, 1'b0);
    reset_mid("t6_rst_rd_resp", 1'b0);
    do_read("t6_after_rd", BASE + 32'h50, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a  = ($urandom_range(0, 4) != 0) ? BASE + 32'($urandom_range(0, 4095)) : $urandom();
      b  = ($urandom_range(0, 4) != 0) ? BASE + 32'($urandom_range(0, 4095)) : $urandom();
      st = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom());
      kind = $urandom_range(0, 2);
      if (kind == 0)
        do_write("rnd_write", a, {$urandom(), $urandom()}, st, $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
      else if (kind == 1)
        do_read("rnd_read", a, $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
      else
        do_both("rnd_pair", a, {$urandom(), $urandom()}, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
